axi_sram_arbiter: RTL and testbench
===================================

Name: axi_sram_arbiter

Overview:
Arbitrates the CPU's instruction-fetch and data-memory SRAM-like request ports onto one AXI master port. Only one AXI transaction is outstanding at a time. The data port has fixed priority over the instruction port, because the MEM stage is older than IF. Sits between the pipeline (IF/MEM stages) and the top-level AXI wrapper; the wrapper ties off the constant AXI fields.

Parameters:
ID_W, 4, width of arid/awid
INST_ID, 0, arid used for instruction reads
DATA_ID, 1, arid/awid used for data accesses

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_req  in  1  IF read request (word, read-only)
inst_addr  in  32  IF address
inst_addr_ok  out  1  IF request accepted this cycle
inst_data_ok  out  1  IF read data valid, 1-cycle pulse
inst_rdata  out  32  IF read data
data_req  in  1  MEM request
data_wr  in  1  1=write, 0=read
data_size  in  2  0=byte, 1=half, 2=word (3 treated as 2)
data_addr  in  32  MEM address
data_wdata  in  32  MEM write data
data_addr_ok  out  1  MEM request accepted this cycle
data_data_ok  out  1  MEM read data / write done, 1-cycle pulse
data_rdata  out  32  MEM read data
arid  out  ID_W  read id
araddr  out  32  read address
arsize  out  3  {0,data_size} for data; 2 for inst
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data ready
awid  out  ID_W  always DATA_ID
awaddr  out  32  write address
awsize  out  3  {0,data_size}
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  byte strobes
wvalid  out  1  write data valid (wlast tied 1 by wrapper)
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- FSM states: IDLE, RADDR, RDATA, WADDR, WRESP. Reset → IDLE; every valid/ready/ok output is 0; all latched address/data/id registers are 0.
- IDLE: data_addr_ok = data_req. inst_addr_ok = inst_req & ~data_req. Both are combinational and asserted only in IDLE.
- On acceptance, latch owner, addr, size, wdata and wr. Data write → WADDR; any read → RADDR. No request → stay in IDLE.
- RADDR: arvalid=1, with arid/araddr/arsize from the latches and held stable. arready → RDATA.
- RDATA: rready=1. On rvalid: latch rdata into the owner's rdata register, pulse the owner's data_ok on the next cycle, and go → IDLE.
- WADDR: awvalid and wvalid are raised together. Each drops independently after its own handshake (aw_done/w_done flags). Both done (same cycle or different cycles) → WRESP.
- WRESP: bready=1. On bvalid: pulse data_data_ok on the next cycle, go → IDLE.
- wstrb: size0 → 4'b0001 << addr[1:0]. size1 → 4'b0011 << {addr[1],1'b0}. size2/3 → 4'b1111. wdata is passed unmodified; the CPU pre-replicates bytes.
- Back-to-back: a new request can be accepted in the same cycle the previous transaction's data_ok pulses.
- inst_rdata/data_rdata hold their last value until overwritten.
- Unaligned addresses are passed through unchecked; the exception logic lives upstream.
- A requester must hold req/addr/wdata stable until addr_ok. After addr_ok, the latched copy is used.
- rst mid-transaction: immediate return to IDLE, all valids drop, no data_ok is issued. The AXI slave shares rst.

Decomposition:
- Shared package (define.v): FSM state encodings, INST_ID/DATA_ID defaults, size codes.
- Sub-module axi_wstrb_gen (size, addr[1:0] → wstrb), purely combinational.
- Everything else stays in one module.

Test Plan:
- Inst read: inst_req, addr 0xBFC00000, arready=1 and rdata=0x3C1D0001 two cycles later → arid=0, araddr=0xBFC00000, arsize=2; inst_data_ok pulses once with inst_rdata=0x3C1D0001.
- Simultaneous inst_req and data_req (read, 0x80001000) → only data_addr_ok=1; inst is granted on the first IDLE after data_data_ok.
- Byte write, addr 0x80000003, size 0, wdata 0xAB → wstrb=4'b1000, awsize=0; data_data_ok one cycle after bvalid.
- Write with awready at cycle 1 and wready at cycle 4 → awvalid drops after cycle 1, wvalid holds until cycle 4, and WRESP is entered only after both handshakes.
- Half write, addr 0x2, size 1 → wstrb=4'b1100. Size 3 → wstrb=4'b1111.
- rst asserted while in RDATA with rvalid=0 → next cycle arvalid=rready=0, state IDLE, no data_ok; a subsequent inst_req completes normally.

Source files
------------

// File: rtl/axi_sram_arbiter_pkg.sv
// Shared definitions for the SRAM-to-AXI arbiter: FSM states, default ids, size codes.
package axi_sram_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4
  } state_e;

  localparam int unsigned INST_ID_DEF = 0;
  localparam int unsigned DATA_ID_DEF = 1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Size code 3 has no meaning on a 32-bit bus; fold it onto a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/axi_sram_arbiter_wstrb_gen.sv
// Byte-strobe generator for a single-beat 32-bit write.
module axi_sram_arbiter_wstrb_gen
  import axi_sram_arbiter_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr,
  output logic [3:0] wstrb
);

  // Select enabled byte lanes from access size and low address bits.
  always_comb begin
    wstrb = 4'b1111;
    case (size)
      SIZE_BYTE: wstrb = 4'b0001 << addr;
      SIZE_HALF: wstrb = 4'b0011 << {addr[1], 1'b0};
      default:   wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/axi_sram_arbiter.sv
// Arbitrates IF and MEM SRAM-like ports onto one AXI master, one transaction at a time.
module axi_sram_arbiter
  import axi_sram_arbiter_pkg::*;
#(
  parameter int unsigned ID_W    = 4,
  parameter int unsigned INST_ID = INST_ID_DEF,
  parameter int unsigned DATA_ID = DATA_ID_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [31:0]     inst_addr,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [31:0]     inst_rdata,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [31:0]     data_addr,
  input  logic [31:0]     data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [31:0]     data_rdata,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [2:0]      arsize,
  output logic            arvalid,
  input  logic            arready,
  input  logic [31:0]     rdata,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [2:0]      awsize,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wvalid,
  input  logic            wready,
  input  logic            bvalid,
  output logic            bready
);

  state_e      state_q, state_d;
  logic        owner_data_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic        aw_done_q;
  logic        w_done_q;

  // Latched request fields drive the AXI payload for the whole transaction.
  assign arid   = owner_data_q ? ID_W'(DATA_ID) : ID_W'(INST_ID);
  assign araddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awid   = ID_W'(DATA_ID);
  assign awaddr = addr_q;
  assign awsize = {1'b0, size_q};
  assign wdata  = wdata_q;

  axi_sram_arbiter_wstrb_gen u_wstrb_gen (
    .size  (size_q),
    .addr  (addr_q[1:0]),
    .wstrb (wstrb)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs; MEM wins over IF in IDLE.
  always_comb begin
    state_d      = state_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (state_q)
      IDLE: begin
        data_addr_ok = data_req;
        inst_addr_ok = inst_req & ~data_req;
        if (data_req)      state_d = data_wr ? WADDR : RADDR;
        else if (inst_req) state_d = RADDR;
      end
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        rready = 1'b1;
        if (rvalid) state_d = IDLE;
      end
      WADDR: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        if ((aw_done_q | awready) && (w_done_q | wready)) state_d = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latches, write-channel done flags, read data and data_ok pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_data_q <= 1'b0;
      addr_q       <= 32'd0;
      size_q       <= 2'd0;
      wdata_q      <= 32'd0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rdata   <= 32'd0;
      data_rdata   <= 32'd0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      if (data_addr_ok) begin
        owner_data_q <= 1'b1;
        addr_q       <= data_addr;
        size_q       <= norm_size(data_size);
        wdata_q      <= data_wdata;
      end else if (inst_addr_ok) begin
        owner_data_q <= 1'b0;
        addr_q       <= inst_addr;
        size_q       <= SIZE_WORD;
      end
      if (state_q == IDLE) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (awvalid && awready) aw_done_q <= 1'b1;
      if (wvalid && wready)   w_done_q  <= 1'b1;
      if (state_q == RDATA && rvalid) begin
        if (owner_data_q) begin
          data_rdata   <= rdata;
          data_data_ok <= 1'b1;
        end else begin
          inst_rdata   <= rdata;
          inst_data_ok <= 1'b1;
        end
      end
      if (state_q == WRESP && bvalid) data_data_ok <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_sram_arbiter.sv
// Self-checking bench for axi_sram_arbiter with a data_ok scoreboard.
module tb_axi_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  typedef struct {
    bit          is_data;
    bit          is_write;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  axi_sram_arbiter #(.ID_W(4), .INST_ID(0), .DATA_ID(1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every data_ok pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && (inst_data_ok || data_data_ok)) begin
      n_cmp++;
      if (inst_data_ok && data_data_ok) begin
        n_err++;
        $display("FAIL dual_data_ok: inst_data_ok=1 data_data_ok=1, required only one");
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_data_ok: inst=%0b data=%0b with nothing outstanding",
                 inst_data_ok, data_data_ok);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (data_data_ok !== e.is_data) begin
          n_err++;
          $display("FAIL data_ok_owner: got data=%0b, required data=%0b", data_data_ok, e.is_data);
        end else if (!e.is_write && e.is_data && data_rdata !== e.rdata) begin
          n_err++;
          $display("FAIL data_rdata: got %08h, required %08h", data_rdata, e.rdata);
        end else if (!e.is_data && inst_rdata !== e.rdata) begin
          n_err++;
          $display("FAIL inst_rdata: got %08h, required %08h", inst_rdata, e.rdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completes a read already in RADDR: arready now, rvalid with data next cycle.
  task automatic serve_read(input bit is_data, input logic [31:0] d);
    exp_t e;
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = d;
    e.is_data = is_data; e.is_write = 1'b0; e.rdata = d;
    exp_q.push_back(e);
    step();
    rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    #1;
    n_cmp++;
    if ({arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok,
         inst_addr_ok, data_addr_ok} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %09b, required 000000000",
               {arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok,
                inst_addr_ok, data_addr_ok});
    end
    n_cmp++;
    if ({inst_rdata, data_rdata, araddr, wdata} !== 128'd0 || arid !== 4'd0) begin
      n_err++;
      $display("FAIL reset_regs: got rd=%08h/%08h addr=%08h wd=%08h id=%0d, required zeros",
               inst_rdata, data_rdata, araddr, wdata, arid);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_inst_read();
    exp_t e;
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0000;
    #1;
    n_cmp++;
    if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
      n_err++;
      $display("FAIL inst_addr_ok: got %0b/%0b, required 1/0", inst_addr_ok, data_addr_ok);
    end
    step();
    inst_req = 1'b0;
    n_cmp++;
    if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'hBFC0_0000 || arsize !== 3'd2) begin
      n_err++;
      $display("FAIL inst_ar: got v=%0b id=%0d a=%08h s=%0d, required 1 0 bfc00000 2",
               arvalid, arid, araddr, arsize);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    n_cmp++;
    if (arvalid !== 1'b0 || rready !== 1'b1) begin
      n_err++;
      $display("FAIL inst_rdata_state: got arvalid=%0b rready=%0b, required 0 1", arvalid, rready);
    end
    step();
    rvalid = 1'b1;
    rdata  = 32'h3C1D_0001;
    e.is_data = 1'b0; e.is_write = 1'b0; e.rdata = 32'h3C1D_0001;
    exp_q.push_back(e);
    step();
    rvalid = 1'b0;
    rdata  = 32'hDEAD_BEEF;
    step();
    step();
    n_cmp++;
    if (inst_rdata !== 32'h3C1D_0001) begin
      n_err++;
      $display("FAIL inst_rdata_hold: got %08h, required 3c1d0001", inst_rdata);
    end
  endtask

  task automatic test_priority();
    inst_req   = 1'b1;
    inst_addr  = 32'hBFC0_0004;
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_size  = 2'd2;
    data_addr  = 32'h8000_1000;
    #1;
    n_cmp++;
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
      n_err++;
      $display("FAIL prio_addr_ok: got data=%0b inst=%0b, required 1 0", data_addr_ok, inst_addr_ok);
    end
    step();
    data_req = 1'b0;
    n_cmp++;
    if (inst_addr_ok !== 1'b0 || arid !== 4'd1 || araddr !== 32'h8000_1000 || arsize !== 3'd2) begin
      n_err++;
      $display("FAIL prio_ar: got iok=%0b id=%0d a=%08h s=%0d, required 0 1 80001000 2",
               inst_addr_ok, arid, araddr, arsize);
    end
    serve_read(1'b1, 32'h1122_3344);
    n_cmp++;
    if (data_data_ok !== 1'b1 || inst_addr_ok !== 1'b1) begin
      n_err++;
      $display("FAIL back_to_back: got data_ok=%0b inst_addr_ok=%0b, required 1 1",
               data_data_ok, inst_addr_ok);
    end
    step();
    inst_req = 1'b0;
    n_cmp++;
    if (arid !== 4'd0 || araddr !== 32'hBFC0_0004 || arvalid !== 1'b1) begin
      n_err++;
      $display("FAIL prio_inst_ar: got id=%0d a=%08h v=%0b, required 0 bfc00004 1",
               arid, araddr, arvalid);
    end
    serve_read(1'b0, 32'hCAFE_F00D);
    step();
  endtask

  task automatic test_byte_write();
    exp_t e;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd0;
    data_addr  = 32'h8000_0003;
    data_wdata = 32'h0000_00AB;
    step();
    data_req = 1'b0;
    n_cmp++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'b1000 || awsize !== 3'd0 ||
        awaddr !== 32'h8000_0003 || wdata !== 32'h0000_00AB || awid !== 4'd1) begin
      n_err++;
      $display("FAIL byte_write: got v=%0b%0b strb=%04b sz=%0d a=%08h d=%08h id=%0d",
               awvalid, wvalid, wstrb, awsize, awaddr, wdata, awid);
    end
    awready = 1'b1;
    wready  = 1'b1;
    step();
    awready = 1'b0;
    wready  = 1'b0;
    n_cmp++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin
      n_err++;
      $display("FAIL byte_wresp: got aw=%0b w=%0b b=%0b, required 0 0 1", awvalid, wvalid, bready);
    end
    bvalid = 1'b1;
    #1;
    n_cmp++;
    if (data_data_ok !== 1'b0) begin
      n_err++;
      $display("FAIL early_data_ok: got %0b during bvalid, required 0", data_data_ok);
    end
    e.is_data = 1'b1; e.is_write = 1'b1; e.rdata = 32'd0;
    exp_q.push_back(e);
    step();
    bvalid = 1'b0;
    step();
  endtask

  task automatic test_split_handshake();
    exp_t e;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd2;
    data_addr  = 32'h8000_0010;
    data_wdata = 32'h1234_5678;
    step();
    data_req = 1'b0;
    awready  = 1'b1;
    for (int cyc = 2; cyc <= 5; cyc++) begin
      step();
      awready = 1'b0;
      wready  = (cyc == 4);
      n_cmp++;
      if (awvalid !== 1'b0 || wvalid !== 1'b1 || bready !== 1'b0) begin
        n_err++;
        $display("FAIL split_c%0d: got aw=%0b w=%0b b=%0b, required 0 1 0",
                 cyc, awvalid, wvalid, bready);
      end
      if (cyc == 4) break;
    end
    step();
    wready = 1'b0;
    n_cmp++;
    if (wvalid !== 1'b0 || bready !== 1'b1) begin
      n_err++;
      $display("FAIL split_wresp: got w=%0b b=%0b, required 0 1", wvalid, bready);
    end
    bvalid = 1'b1;
    e.is_data = 1'b1; e.is_write = 1'b1; e.rdata = 32'd0;
    exp_q.push_back(e);
    step();
    bvalid = 1'b0;
    step();
  endtask

  task automatic test_wstrb();
    logic [1:0]  sizes [4] = '{2'd1, 2'd3, 2'd0, 2'd1};
    logic [31:0] addrs [4] = '{32'h0000_0002, 32'h0000_0005, 32'h0000_0001, 32'h0000_0001};
    logic [3:0]  strbs [4] = '{4'b1100, 4'b1111, 4'b0010, 4'b0011};
    logic [2:0]  szs   [4] = '{3'd1, 3'd2, 3'd0, 3'd1};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      data_req   = 1'b1;
      data_wr    = 1'b1;
      data_size  = sizes[i];
      data_addr  = addrs[i];
      data_wdata = 32'($urandom);
      step();
      data_req = 1'b0;
      n_cmp++;
      if (wstrb !== strbs[i] || awsize !== szs[i]) begin
        n_err++;
        $display("FAIL wstrb_%0d: got strb=%04b sz=%0d, required %04b %0d",
                 i, wstrb, awsize, strbs[i], szs[i]);
      end
      awready = 1'b1;
      wready  = 1'b1;
      step();
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b1;
      e.is_data = 1'b1; e.is_write = 1'b1; e.rdata = 32'd0;
      exp_q.push_back(e);
      step();
      bvalid = 1'b0;
    end
    step();
  endtask

  task automatic test_reset_mid();
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0100;
    step();
    inst_req = 1'b0;
    arready  = 1'b1;
    step();
    arready = 1'b0;
    n_cmp++;
    if (rready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre_rdata: got rready=%0b, required 1", rready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got arv=%0b rr=%0b iok=%0b dok=%0b, required 0 0 0 0",
               arvalid, rready, inst_data_ok, data_data_ok);
    end
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0200;
    #1;
    n_cmp++;
    if (inst_addr_ok !== 1'b1) begin
      n_err++;
      $display("FAIL mid_idle: got inst_addr_ok=%0b, required 1", inst_addr_ok);
    end
    step();
    inst_req = 1'b0;
    serve_read(1'b0, 32'h0BAD_CAFE);
    step();
    step();
  endtask

  initial begin
    rst        = 1'b1;
    inst_req   = 1'b0;
    inst_addr  = 32'd0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = 32'd0;
    data_wdata = 32'd0;
    arready    = 1'b0;
    rdata      = 32'd0;
    rvalid     = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    test_reset();
    test_inst_read();
    test_priority();
    test_byte_write();
    test_split_handshake();
    test_wstrb();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_completions: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
